// File: rtl/rx_iq_frame_scheduler.sv
// Pairs RX1/RX2 DDC samples into IQ frames and queues them in a FIFO that the
// bus interface drains with edge-detected read strobes; flags drops as overruns.
module rx_iq_frame_scheduler #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IQ_WIDTH   = 24
) (
  input  logic                       clk_in,
  input  logic                       reset_n,
  input  logic                       rx1_enable,
  input  logic                       rx2_enable,
  input  logic signed [IQ_WIDTH-1:0] RX1_I,
  input  logic signed [IQ_WIDTH-1:0] RX1_Q,
  input  logic                       RX1_valid,
  input  logic signed [IQ_WIDTH-1:0] RX2_I,
  input  logic signed [IQ_WIDTH-1:0] RX2_Q,
  input  logic                       RX2_valid,
  input  logic                       IQ_RX_READ_REQ,
  input  logic                       IQ_RX_READ_CLK,
  input  logic                       overrun_clr,
  output logic signed [IQ_WIDTH-1:0] OUT_RX1_I,
  output logic signed [IQ_WIDTH-1:0] OUT_RX1_Q,
  output logic signed [IQ_WIDTH-1:0] OUT_RX2_I,
  output logic signed [IQ_WIDTH-1:0] OUT_RX2_Q,
  output logic                       in_empty,
  output logic                       iq_overrun,
  output logic [DEPTH_LOG2:0]        fifo_level,
  output logic [7:0]                 slip_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic signed [IQ_WIDTH-1:0] rx1_i;
    logic signed [IQ_WIDTH-1:0] rx1_q;
    logic signed [IQ_WIDTH-1:0] rx2_i;
    logic signed [IQ_WIDTH-1:0] rx2_q;
  } frame_t;

  typedef enum logic [1:0] {IDLE, WAIT_PAIR, COMMIT} state_t;

  state_t          state_q, state_d;
  frame_t          frame_q, frame_d;
  frame_t          out_q, out_d;
  frame_t          mem_q [DEPTH];
  logic            mode_rx2_q, mode_rx2_d;
  logic [7:0]      slip_q, slip_d;
  logic            ovr_q, ovr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            rclk_q;
  logic            empty, full, pop, wr_en, drop, slip_inc;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}});
  assign pop   = IQ_RX_READ_CLK & ~rclk_q & IQ_RX_READ_REQ & ~empty;
  assign wr_en = (state_q == COMMIT) & (~full | pop);
  assign drop  = (state_q == COMMIT) & full & ~pop;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    mode_rx2_d = mode_rx2_q;
    slip_inc   = 1'b0;
    case (state_q)
      // COMMIT lasts one cycle and treats new strobes as IDLE would
      IDLE, COMMIT: begin
        if (state_q == IDLE) mode_rx2_d = rx1_enable & rx2_enable;
        state_d = IDLE;
        if (rx1_enable && RX1_valid) begin
          frame_d.rx1_i = RX1_I;
          frame_d.rx1_q = RX1_Q;
          if (!mode_rx2_q) begin
            frame_d.rx2_i = '0;
            frame_d.rx2_q = '0;
            state_d       = COMMIT;
          end else if (RX2_valid) begin
            frame_d.rx2_i = RX2_I;
            frame_d.rx2_q = RX2_Q;
            state_d       = COMMIT;
          end else begin
            state_d = WAIT_PAIR;
          end
        end
      end
      WAIT_PAIR: begin
        if (!rx1_enable) begin
          state_d = IDLE;
        end else begin
          if (RX1_valid) begin
            frame_d.rx1_i = RX1_I;
            frame_d.rx1_q = RX1_Q;
            slip_inc      = 1'b1;
          end
          if (RX2_valid) begin
            frame_d.rx2_i = RX2_I;
            frame_d.rx2_q = RX2_Q;
            state_d       = COMMIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slip_d = slip_q;
    if (slip_inc && slip_q != 8'hFF) slip_d = slip_q + 8'd1;
    ovr_d = ovr_q;
    if (overrun_clr) ovr_d = 1'b0;
    if (drop)        ovr_d = 1'b1;
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    // Head register: bypass the frame being written when it becomes the head
    out_d = out_q;
    if (wr_en && wr_ptr_q == rd_ptr_d)
      out_d = frame_q;
    else if (pop && rd_ptr_d != wr_ptr_q)
      out_d = mem_q[rd_ptr_d[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      out_q      <= '0;
      mode_rx2_q <= 1'b0;
      slip_q     <= '0;
      ovr_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      out_q      <= out_d;
      mode_rx2_q <= mode_rx2_d;
      slip_q     <= slip_d;
      ovr_q      <= ovr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rclk_q     <= IQ_RX_READ_CLK;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid
  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= frame_q;
  end

  assign OUT_RX1_I  = out_q.rx1_i;
  assign OUT_RX1_Q  = out_q.rx1_q;
  assign OUT_RX2_I  = out_q.rx2_i;
  assign OUT_RX2_Q  = out_q.rx2_q;
  assign in_empty   = empty;
  assign iq_overrun = ovr_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign slip_count = slip_q;
endmodule

// File: tb/tb_rx_iq_frame_scheduler.sv
// Scenario bench for rx_iq_frame_scheduler: directed cases plus randomized
// bursts checked against a transaction-level pairing/queue model.
module tb_rx_iq_frame_scheduler;
  logic clk_in = 1'b0;
  logic reset_n;
  logic rx1_enable, rx2_enable;
  logic signed [23:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic RX1_valid, RX2_valid;
  logic IQ_RX_READ_REQ, IQ_RX_READ_CLK, overrun_clr;
  logic signed [23:0] OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q;
  logic in_empty, iq_overrun;
  logic [4:0] fifo_level;
  logic [7:0] slip_count;

  rx_iq_frame_scheduler #(.DEPTH_LOG2(4), .IQ_WIDTH(24)) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .rx1_enable(rx1_enable), .rx2_enable(rx2_enable),
    .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX1_valid(RX1_valid),
    .RX2_I(RX2_I), .RX2_Q(RX2_Q), .RX2_valid(RX2_valid),
    .IQ_RX_READ_REQ(IQ_RX_READ_REQ), .IQ_RX_READ_CLK(IQ_RX_READ_CLK),
    .overrun_clr(overrun_clr),
    .OUT_RX1_I(OUT_RX1_I), .OUT_RX1_Q(OUT_RX1_Q),
    .OUT_RX2_I(OUT_RX2_I), .OUT_RX2_Q(OUT_RX2_Q),
    .in_empty(in_empty), .iq_overrun(iq_overrun),
    .fifo_level(fifo_level), .slip_count(slip_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [23:0] i1, q1, i2, q2;
  } fr_t;

  fr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  slip_exp;
  localparam logic [113:0] RST_STATE = {1'b1, 1'b0, 5'd0, 8'd0, 96'd0};

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [23:0] r24();
    return 24'($urandom);
  endfunction

  function automatic fr_t rnd_fr();
    return {r24(), r24(), r24(), r24()};
  endfunction

  function automatic fr_t cur_out();
    return {OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q};
  endfunction

  function automatic logic [113:0] status();
    return {in_empty, iq_overrun, fifo_level, slip_count, cur_out()};
  endfunction

  task automatic strobe(input bit v1, input bit v2, input fr_t f);
    RX1_I = f.i1; RX1_Q = f.q1; RX2_I = f.i2; RX2_Q = f.q2;
    RX1_valid = v1; RX2_valid = v2;
    tick();
    RX1_valid = 1'b0; RX2_valid = 1'b0;
  endtask

  task automatic pop_once();
    IQ_RX_READ_REQ = 1'b1;
    IQ_RX_READ_CLK = 1'b1;
    tick();
    IQ_RX_READ_CLK = 1'b0;
    tick();
  endtask

  task automatic set_mode(input bit m2);
    rx1_enable = 1'b1;
    rx2_enable = m2;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++;
    if (status() !== RST_STATE) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", status(), RST_STATE);
    end
    @(posedge clk_in); #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_rx1_only();
    fr_t f;
    set_mode(1'b0);
    f = {24'h000123, 24'hFFFF00, r24(), r24()};
    strobe(1'b1, 1'b0, f);
    total++;
    if (in_empty !== 1'b1) begin
      bad++; $display("FAIL rx1_latency_early got=%b exp=1", in_empty);
    end
    tick();
    f.i2 = '0; f.q2 = '0;
    total++;
    if ({in_empty, fifo_level, cur_out()} !== {1'b0, 5'd1, f}) begin
      bad++; $display("FAIL rx1_only got=%h exp=%h", {in_empty, fifo_level, cur_out()}, {1'b0, 5'd1, f});
    end
    pop_once();
    total++;
    if ({in_empty, fifo_level} !== {1'b1, 5'd0}) begin
      bad++; $display("FAIL rx1_pop got=%h exp=%h", {in_empty, fifo_level}, {1'b1, 5'd0});
    end
  endtask

  task automatic test_pairing();
    fr_t a, b, c, d, e;
    set_mode(1'b1);
    a = rnd_fr(); b = rnd_fr(); c = rnd_fr(); d = rnd_fr();
    strobe(1'b1, 1'b0, a);
    strobe(1'b1, 1'b0, b);
    strobe(1'b0, 1'b1, c);
    tick();
    e = {b.i1, b.q1, c.i2, c.q2};
    total++;
    if ({slip_count, fifo_level, cur_out()} !== {8'd1, 5'd1, e}) begin
      bad++; $display("FAIL pair_slip got=%h exp=%h", {slip_count, fifo_level, cur_out()}, {8'd1, 5'd1, e});
    end
    strobe(1'b1, 1'b1, d);
    tick();
    total++;
    if ({slip_count, fifo_level} !== {8'd1, 5'd2}) begin
      bad++; $display("FAIL pair_same_cycle got=%h exp=%h", {slip_count, fifo_level}, {8'd1, 5'd2});
    end
    pop_once();
    total++;
    if (cur_out() !== d) begin
      bad++; $display("FAIL pair_second got=%h exp=%h", cur_out(), d);
    end
    pop_once();
    total++;
    if (in_empty !== 1'b1) begin
      bad++; $display("FAIL pair_drain got=%b exp=1", in_empty);
    end
  endtask

  task automatic test_overrun();
    fr_t fl[17];
    set_mode(1'b0);
    for (int i = 0; i < 17; i++) begin
      fl[i] = rnd_fr();
      fl[i].i2 = '0; fl[i].q2 = '0;
      strobe(1'b1, 1'b0, fl[i]);
      tick();
    end
    total++;
    if ({fifo_level, iq_overrun} !== {5'd16, 1'b1}) begin
      bad++; $display("FAIL overrun_full got=%h exp=%h", {fifo_level, iq_overrun}, {5'd16, 1'b1});
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cur_out() !== fl[i]) begin
        bad++; $display("FAIL overrun_order[%0d] got=%h exp=%h", i, cur_out(), fl[i]);
      end
      pop_once();
    end
    total++;
    if (in_empty !== 1'b1) begin
      bad++; $display("FAIL overrun_drain got=%b exp=1", in_empty);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    total++;
    if (iq_overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_clr got=%b exp=0", iq_overrun);
    end
  endtask

  task automatic test_full_pop();
    fr_t f;
    set_mode(1'b0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      f = rnd_fr(); f.i2 = '0; f.q2 = '0;
      exp_q.push_back(f);
      strobe(1'b1, 1'b0, f);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      f = rnd_fr(); f.i2 = '0; f.q2 = '0;
      strobe(1'b1, 1'b0, f);
      IQ_RX_READ_REQ = 1'b1;
      IQ_RX_READ_CLK = 1'b1;
      total++;
      if (cur_out() !== exp_q[0]) begin
        bad++; $display("FAIL full_pop_head[%0d] got=%h exp=%h", i, cur_out(), exp_q[0]);
      end
      tick();
      IQ_RX_READ_CLK = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(f);
    end
    tick();
    total++;
    if ({fifo_level, iq_overrun} !== {5'd16, 1'b0}) begin
      bad++; $display("FAIL full_pop_level got=%h exp=%h", {fifo_level, iq_overrun}, {5'd16, 1'b0});
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cur_out() !== exp_q[0]) begin
        bad++; $display("FAIL full_pop_drain[%0d] got=%h exp=%h", i, cur_out(), exp_q[0]);
      end
      void'(exp_q.pop_front());
      pop_once();
    end
    total++;
    if (in_empty !== 1'b1) begin
      bad++; $display("FAIL full_pop_empty got=%b exp=1", in_empty);
    end
  endtask

  task automatic test_reset_mid();
    set_mode(1'b0);
    for (int i = 0; i < 5; i++) begin
      strobe(1'b1, 1'b0, rnd_fr());
      tick();
    end
    set_mode(1'b1);
    strobe(1'b1, 1'b0, rnd_fr());
    total++;
    if (fifo_level !== 5'd5) begin
      bad++; $display("FAIL reset_mid_pre got=%0d exp=5", fifo_level);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (status() !== RST_STATE) begin
      bad++; $display("FAIL reset_mid_async got=%h exp=%h", status(), RST_STATE);
    end
    tick();
    reset_n = 1'b1;
    tick();
    pop_once();
    total++;
    if (status() !== RST_STATE) begin
      bad++; $display("FAIL reset_mid_empty_pop got=%h exp=%h", status(), RST_STATE);
    end
    set_mode(1'b1);
    strobe(1'b0, 1'b1, rnd_fr());
    tick(); tick();
    total++;
    if (in_empty !== 1'b1) begin
      bad++; $display("FAIL lone_rx2 got=%b exp=1", in_empty);
    end
  endtask

  task automatic test_random();
    fr_t f, pf, nf;
    bit  m2, v1, v2, pend;
    slip_exp = 0;
    for (int ph = 0; ph < 6; ph++) begin
      m2 = 1'($urandom_range(0, 1));
      set_mode(m2);
      exp_q.delete();
      pend = 1'b0;
      pf = '0;
      for (int c = 0; c < 60 && exp_q.size() < 14; c++) begin
        v1 = ($urandom_range(0, 2) == 0);
        v2 = ($urandom_range(0, 2) == 0);
        f  = rnd_fr();
        if (!m2) begin
          if (v1) begin nf = f; nf.i2 = '0; nf.q2 = '0; exp_q.push_back(nf); end
        end else if (pend) begin
          if (v1) begin
            pf.i1 = f.i1; pf.q1 = f.q1;
            if (slip_exp < 255) slip_exp++;
          end
          if (v2) begin
            exp_q.push_back({pf.i1, pf.q1, f.i2, f.q2});
            pend = 1'b0;
          end
        end else if (v1) begin
          if (v2) exp_q.push_back(f);
          else begin pf = f; pend = 1'b1; end
        end
        strobe(v1, v2, f);
      end
      tick(); tick();
      total++;
      if ({fifo_level, slip_count} !== {5'(exp_q.size()), 8'(slip_exp)}) begin
        bad++; $display("FAIL rand_level_slip[%0d] got=%h exp=%h", ph, {fifo_level, slip_count}, {5'(exp_q.size()), 8'(slip_exp)});
      end
      rx1_enable = 1'b0;
      tick();
      while (exp_q.size() > 0) begin
        total++;
        if (cur_out() !== exp_q[0]) begin
          bad++; $display("FAIL rand_frame[%0d] got=%h exp=%h", ph, cur_out(), exp_q[0]);
        end
        void'(exp_q.pop_front());
        pop_once();
      end
      total++;
      if (in_empty !== 1'b1) begin
        bad++; $display("FAIL rand_empty[%0d] got=%b exp=1", ph, in_empty);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rx1_enable = 1'b0; rx2_enable = 1'b0;
    RX1_I = '0; RX1_Q = '0; RX2_I = '0; RX2_Q = '0;
    RX1_valid = 1'b0; RX2_valid = 1'b0;
    IQ_RX_READ_REQ = 1'b0; IQ_RX_READ_CLK = 1'b0; overrun_clr = 1'b0;
    test_reset();
    test_rx1_only();
    test_pairing();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
